// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared sizes and types for the MIPS register file slice.
//   DATA_W    : register width in bits
//   ADDR_W    : register index width
//   NUM_REGS  : number of architectural registers (2**ADDR_W)
//   ZERO_REG  : index of the hardwired-zero register $0
//   reg_idx_t : register index type
//   word_t    : register data type
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage : mips_pkg

// File: rtl/mips_reg_file_decoder_5to32.sv
// -----------------------------------------------------------------------------
// decoder_5to32
// Write-enable decoder for the register file: turns a 5-bit register index
// into a one-hot enable vector, gated by a global enable.
// Ports:
//   en     : in  1  global enable (RegWrite)
//   idx    : in  5  register index
//   onehot : out 32 bit idx set when en=1, all zeros otherwise
// -----------------------------------------------------------------------------
module decoder_5to32
    import mips_pkg::*;
(
    input  logic                en,
    input  reg_idx_t            idx,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule : decoder_5to32

// File: rtl/mips_reg_file.sv
// -----------------------------------------------------------------------------
// mips_reg_file
// 32 x 32-bit general-purpose register file for the pipelined MIPS datapath.
// Two combinational read ports (rs/rt, used in ID) and one synchronous write
// port (from WB). Register $0 is hardwired to zero.
//
// Ports:
//   clk        : in  1       rising-edge clock
//   rst        : in  1       asynchronous, active-high reset (clears all regs)
//   RegWrite   : in  1       write enable from WB
//   write_reg  : in  ADDR_W  destination register index
//   write_data : in  DATA_W  data to write
//   read_reg1  : in  ADDR_W  read port 1 index (rs)
//   read_reg2  : in  ADDR_W  read port 2 index (rt)
//   read_data1 : out DATA_W  read port 1 data
//   read_data2 : out DATA_W  read port 2 data
//
// Build option:
//   REGFILE_BYPASS_EN : when defined, a read of the register being written in
//   the same cycle returns write_data (write-through forwarding), removing the
//   WB-to-ID hazard. When undefined, reads return the stored value until the
//   write edge, and the hazard must be handled outside this block.
// -----------------------------------------------------------------------------
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] dec_onehot;
    logic [NUM_REGS-1:0] wr_en;

    decoder_5to32 u_wr_dec (
        .en     (RegWrite),
        .idx    (write_reg),
        .onehot (dec_onehot)
    );

    // $0 can never be enabled, so it keeps the zero loaded by reset.
    assign wr_en = {dec_onehot[NUM_REGS-1:1], 1'b0};

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en[i]) begin
                regs_d[i] = write_data;
            end
        end
    end

    // Reset wins over any write presented in the same cycle, so a write is
    // only committed on the first rising edge that sees rst low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read select for one port. Index 0 and reset both force zero; the
    // explicit rst term also keeps forwarding from leaking write_data while
    // the array is being cleared.
    function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!rst && (idx != ADDR_W'(ZERO_REG))) begin
            val = regs_q[idx];
`ifdef REGFILE_BYPASS_EN
            if (RegWrite && (write_reg != ADDR_W'(ZERO_REG)) && (idx == write_reg)) begin
                val = write_data;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        read_data1 = read_sel(read_reg1);
        read_data2 = read_sel(read_reg2);
    end

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// -----------------------------------------------------------------------------
// tb_mips_reg_file
// Directed, self-checking bench for mips_reg_file. Expected values are
// hand-derived constants; the same-cycle write/read expectations depend on
// whether REGFILE_BYPASS_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  write_reg = 5'd0;
    logic [31:0] write_data = 32'h0;
    logic [4:0]  read_reg1 = 5'd0;
    logic [4:0]  read_reg2 = 5'd0;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int n_cmp = 0;
    int n_err = 0;

    mips_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after it, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp;

        // ---- reset state ----
        read_reg1 = 5'd5;
        read_reg2 = 5'd31;
        #1 rst = 1'b1;
        #1;
        chk("reset_rd1", read_data1, 32'h0);
        chk("reset_rd2", read_data2, 32'h0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // ---- write r5, then asynchronous clear between edges ----
        RegWrite = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r5_written", read_data1, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1;
        chk("r5_async_clear", read_data1, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("r5_after_clear", read_data1, 32'h0);
        tick();

        // ---- fill r1..r31 on consecutive edges ----
        RegWrite = 1'b1;
        for (int i = 1; i < 32; i++) begin
            write_reg  = 5'(i);
            write_data = 32'h100 + 32'(i);
            tick();
        end
        RegWrite = 1'b0;
        write_reg = 5'd0;
        write_data = 32'h0;

        // ---- sweep both ports ----
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(i);
            #1;
            exp = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            chk($sformatf("sweep_rd1_r%0d", i), read_data1, exp);
            chk($sformatf("sweep_rd2_r%0d", i), read_data2, exp);
        end

        // independent ports at different indices
        read_reg1 = 5'd12; read_reg2 = 5'd30;
        #1;
        chk("indep_rd1", read_data1, 32'h10C);
        chk("indep_rd2", read_data2, 32'h11E);
        tick();

        // ---- $0 immunity ----
        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        read_reg1 = 5'd0;
        #1;
        chk("r0_pre_edge", read_data1, 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r0_post_edge", read_data1, 32'h0);

        // ---- write-enable gating ----
        RegWrite = 1'b0; write_reg = 5'd7; write_data = 32'h12345678;
        read_reg1 = 5'd7;
        tick();
        chk("we_gating_r7", read_data1, 32'h107);

        // ---- same-cycle write/read on r9 ----
        read_reg1 = 5'd9; read_reg2 = 5'd9;
        #1;
        chk("r9_before", read_data2, 32'h109);
        RegWrite = 1'b1; write_reg = 5'd9; write_data = 32'hCAFEF00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp = 32'hCAFEF00D;
`else
        exp = 32'h109;
`endif
        chk("r9_same_cycle_rd2", read_data2, exp);
        chk("r9_same_cycle_rd1", read_data1, exp);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r9_after_rd2", read_data2, 32'hCAFEF00D);
        chk("r9_after_rd1", read_data1, 32'hCAFEF00D);

        // ---- reset in the middle of a write ----
        RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'hA5A5A5A5;
        read_reg1 = 5'd3; read_reg2 = 5'd4;
        #1 rst = 1'b1;
        #1;
        chk("r3_in_reset", read_data1, 32'h0);
        tick();
        chk("r3_edge_in_reset", read_data1, 32'h0);
        #2 rst = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp = 32'hA5A5A5A5;
`else
        exp = 32'h0;
`endif
        chk("r3_after_release", read_data1, exp);
        chk("r4_cleared", read_data2, 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r3_first_edge", read_data1, 32'hA5A5A5A5);
        chk("r4_untouched", read_data2, 32'h0);
        read_reg2 = 5'd31;
        #1;
        chk("r31_cleared", read_data2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mips_reg_file
